// File: rtl/stream_rr_lock_arb_pkg.sv
// stream_rr_lock_arb_pkg: shared sizing helper for stream crossbar index widths
package stream_rr_lock_arb_pkg;
  function automatic int idx_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_rr_lock_arb_if.sv
// stream_rr_lock_arb_if: input streams plus merged output stream of one arbiter
interface stream_rr_lock_arb_if import stream_rr_lock_arb_pkg::*; #(
  parameter int  NumInp    = 4,
  parameter type payload_t = logic,
  parameter int  IdxWidth  = idx_width(NumInp)
);
  payload_t              inp_data [NumInp];
  logic [NumInp-1:0]     inp_valid;
  logic [NumInp-1:0]     inp_ready;
  payload_t              data;
  logic [IdxWidth-1:0]   idx;
  logic                  valid;
  logic                  ready;
  modport master (input inp_data, inp_valid, ready, output inp_ready, data, idx, valid);
  modport slave  (output inp_data, inp_valid, ready, input inp_ready, data, idx, valid);
endinterface

// File: rtl/stream_rr_lock_arb_lzc.sv
// stream_rr_lock_arb_lzc: trailing-zero count of a bit vector with empty flag
module stream_rr_lock_arb_lzc import stream_rr_lock_arb_pkg::*; #(
  parameter int WIDTH    = 4,
  parameter int CntWidth = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]    in,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);
  always_comb begin
    cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (in[i]) cnt = CntWidth'(i);
  end
  assign empty = ~|in;
endmodule

// File: rtl/stream_rr_lock_arb.sv
// stream_rr_lock_arb: round-robin burst arbiter with output lock-in for one crossbar output
module stream_rr_lock_arb import stream_rr_lock_arb_pkg::*; #(
  parameter int  NumInp    = 4,
  parameter type payload_t = logic,
  parameter int  MaxBurst  = 1,
  parameter int  IdxWidth  = idx_width(NumInp)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  flush_i,
  stream_rr_lock_arb_if.master bus
);
  localparam int CW = $clog2(MaxBurst + 1);
  logic [IdxWidth-1:0] ptr_q, lock_idx_q, g, gu, tz, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d, n;
  logic [NumInp-1:0]   rot;
  logic                lock_q, empty, valid, hs, wrap;
  payload_t            data_d;
  // rotate so that bit 0 is the current priority holder
  always_comb begin
    rot = '0;
    for (int i = 0; i < NumInp; i++) rot[i] = bus.inp_valid[(int'(ptr_q) + i) % NumInp];
  end
  stream_rr_lock_arb_lzc #(.WIDTH(NumInp)) u_lzc (.in(rot), .cnt(tz), .empty(empty));
  always_comb begin
    gu     = IdxWidth'((int'(ptr_q) + int'(tz)) % NumInp);
    g      = lock_q ? lock_idx_q : gu;
    valid  = lock_q ? bus.inp_valid[lock_idx_q] : ~empty;
    data_d = bus.inp_data[g];
    hs     = valid & bus.ready & ~rst_i;
    n      = (g == ptr_q) ? cnt_q + 1'b1 : CW'(1);
    wrap   = n == CW'(MaxBurst);
    ptr_d  = wrap ? ((g == IdxWidth'(NumInp - 1)) ? '0 : g + 1'b1) : g;
    cnt_d  = wrap ? '0 : n;
  end
  always_comb begin
    bus.valid = valid & ~rst_i;
    bus.idx   = bus.valid ? g : '0;
    bus.data  = data_d;
    bus.inp_ready = '0;
    for (int i = 0; i < NumInp; i++) bus.inp_ready[i] = hs & (g == IdxWidth'(i));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (valid & ~bus.ready) begin
        lock_q     <= 1'b1;
        lock_idx_q <= g;
      end else if (hs) lock_q <= 1'b0;
      if (hs) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end
    end
  end
`ifndef SYNTHESIS
  // a stalled output must hold; a dropped valid while locked is an upstream violation
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.valid && !bus.ready && !flush_i |=> flush_i || (bus.valid && $stable(bus.data) && $stable(bus.idx)));
  a_onehot: assert property (@(posedge clk_i) $onehot0(bus.inp_ready));
  a_cnt: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q < CW'(MaxBurst));
`endif
endmodule

// File: tb/tb_stream_rr_lock_arb.sv
// tb_stream_rr_lock_arb: directed and scoreboard checks of the lock-in round-robin arbiter
module tb_stream_rr_lock_arb;
  typedef logic [15:0] pl_t;
  logic clk = 0, rst = 1, flush = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  stream_rr_lock_arb_if #(.NumInp(4), .payload_t(pl_t)) ia ();
  stream_rr_lock_arb_if #(.NumInp(4), .payload_t(pl_t)) ib ();
  stream_rr_lock_arb_if #(.NumInp(3), .payload_t(pl_t)) ic ();
  stream_rr_lock_arb_if #(.NumInp(1), .payload_t(pl_t)) id ();
  stream_rr_lock_arb #(.NumInp(4), .payload_t(pl_t), .MaxBurst(1)) dut_a (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ia));
  stream_rr_lock_arb #(.NumInp(4), .payload_t(pl_t), .MaxBurst(3)) dut_b (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ib));
  stream_rr_lock_arb #(.NumInp(3), .payload_t(pl_t), .MaxBurst(2)) dut_c (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ic));
  stream_rr_lock_arb #(.NumInp(1), .payload_t(pl_t), .MaxBurst(1)) dut_d (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(id));
  task automatic idle_all();
    ia.inp_valid = '0; ib.inp_valid = '0; ic.inp_valid = '0; id.inp_valid = '0;
    ia.ready = 0; ib.ready = 0; ic.ready = 0; id.ready = 0; flush = 0;
    for (int i = 0; i < 4; i++) begin
      ia.inp_data[i] = '0;
      ib.inp_data[i] = '0;
    end
    for (int i = 0; i < 3; i++) ic.inp_data[i] = '0;
    id.inp_data[0] = '0;
  endtask
  task automatic reset_all();
    idle_all();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic test_reset();
    idle_all();
    rst = 1;
    ia.inp_valid = '1;
    ia.ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); total++;
      if (ia.valid !== 1'b0 || ia.inp_ready !== 4'b0) begin
        bad++; $display("FAIL reset[%0d] valid=%b rdy=%b exp 0 0000", k, ia.valid, ia.inp_ready);
      end
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk); total++;
    if (ia.valid !== 1'b1 || ia.idx !== 2'd0) begin
      bad++; $display("FAIL reset_first valid=%b idx=%0d exp 1 0", ia.valid, ia.idx);
    end
  endtask
  task automatic test_rr();
    reset_all();
    for (int i = 0; i < 4; i++) ia.inp_data[i] = pl_t'(16'h1000 + i);
    ia.inp_valid = '1;
    ia.ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); total++;
      if (ia.idx !== 2'(k % 4) || ia.inp_ready !== 4'(1 << (k % 4)) || ia.data !== pl_t'(16'h1000 + k % 4)) begin
        bad++; $display("FAIL rr[%0d] idx=%0d rdy=%b data=%h exp idx=%0d", k, ia.idx, ia.inp_ready, ia.data, k % 4);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_burst();
    int exp_b [8] = '{0, 0, 0, 2, 2, 2, 0, 0};
    reset_all();
    ib.inp_valid = 4'b0101;
    ib.ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); total++;
      if (ib.idx !== 2'(exp_b[k]) || ib.valid !== 1'b1) begin
        bad++; $display("FAIL burst[%0d] idx=%0d valid=%b exp %0d 1", k, ib.idx, ib.valid, exp_b[k]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_flush_cnt();
    int exp_f [7] = '{0, 0, 0, 0, 0, 0, 2};
    reset_all();
    ib.inp_valid = 4'b0101;
    ib.ready = 1;
    for (int k = 0; k < 7; k++) begin
      flush = (k == 2);
      @(negedge clk); total++;
      if (ib.idx !== 2'(exp_f[k])) begin
        bad++; $display("FAIL flush_cnt[%0d] idx=%0d exp %0d", k, ib.idx, exp_f[k]);
      end
      @(posedge clk); #1;
    end
    flush = 0;
  endtask
  task automatic test_lock();
    reset_all();
    ia.inp_data[0] = 16'h0000; ia.inp_data[1] = 16'hA5A5; ia.inp_data[3] = 16'h3333;
    ia.inp_valid = 4'b1010;
    ia.ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) ia.inp_valid[0] = 1;
      @(negedge clk); total++;
      if (ia.idx !== 2'd1 || ia.data !== 16'hA5A5 || ia.valid !== 1'b1 || ia.inp_ready !== 4'b0) begin
        bad++; $display("FAIL lock[%0d] idx=%0d data=%h valid=%b rdy=%b exp 1 a5a5 1 0000", k, ia.idx, ia.data, ia.valid, ia.inp_ready);
      end
      @(posedge clk); #1;
    end
    ia.ready = 1;
    @(negedge clk); total++;
    if (ia.inp_ready !== 4'b0010) begin
      bad++; $display("FAIL lock_release rdy=%b exp 0010", ia.inp_ready);
    end
    @(posedge clk); #1 ia.inp_valid[1] = 0;
    @(negedge clk); total++;
    if (ia.idx !== 2'd3 || ia.data !== 16'h3333) begin
      bad++; $display("FAIL lock_next idx=%0d data=%h exp 3 3333", ia.idx, ia.data);
    end
    @(posedge clk); #1 ia.inp_valid[3] = 0;
    @(negedge clk); total++;
    if (ia.idx !== 2'd0) begin
      bad++; $display("FAIL lock_after idx=%0d exp 0", ia.idx);
    end
  endtask
  task automatic test_flush_lock();
    reset_all();
    ia.ready = 1;
    ia.inp_valid = 4'b0001;
    @(negedge clk); @(posedge clk); #1 ia.inp_valid = 4'b0010;
    @(negedge clk); @(posedge clk); #1 ia.inp_valid = 4'b0100; ia.ready = 0;
    @(negedge clk); total++;
    if (ia.idx !== 2'd2 || ia.valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre idx=%0d valid=%b exp 2 1", ia.idx, ia.valid);
    end
    @(posedge clk); #1 ia.inp_valid = 4'b0001; flush = 1;
    @(negedge clk); total++;
    if (ia.valid !== 1'b0 || ia.inp_ready !== 4'b0) begin
      bad++; $display("FAIL flush_cycle valid=%b rdy=%b exp 0 0000", ia.valid, ia.inp_ready);
    end
    @(posedge clk); #1 flush = 0;
    @(negedge clk); total++;
    if (ia.valid !== 1'b1 || ia.idx !== 2'd0) begin
      bad++; $display("FAIL flush_after valid=%b idx=%0d exp 1 0", ia.valid, ia.idx);
    end
    @(posedge clk); #1 ia.ready = 1;
    @(negedge clk); total++;
    if (ia.inp_ready !== 4'b0001) begin
      bad++; $display("FAIL flush_hs rdy=%b exp 0001", ia.inp_ready);
    end
  endtask
  task automatic test_single();
    reset_all();
    id.inp_data[0] = 16'hBEEF;
    id.inp_valid = 1'b1;
    @(negedge clk); total++;
    if (id.valid !== 1'b1 || id.idx !== 1'b0 || id.data !== 16'hBEEF || id.inp_ready !== 1'b0) begin
      bad++; $display("FAIL single_stall valid=%b idx=%0d data=%h rdy=%b exp 1 0 beef 0", id.valid, id.idx, id.data, id.inp_ready);
    end
    @(posedge clk); #1 id.ready = 1;
    @(negedge clk); total++;
    if (id.inp_ready !== 1'b1) begin
      bad++; $display("FAIL single_hs rdy=%b exp 1", id.inp_ready);
    end
  endtask
  task automatic test_random();
    localparam int NT = 300;
    int sent [3] = '{0, 0, 0};
    int got [3] = '{0, 0, 0};
    int hk;
    pl_t e;
    reset_all();
    for (int c = 0; c < 20000 && (got[0] < NT || got[1] < NT || got[2] < NT); c++) begin
      for (int i = 0; i < 3; i++)
        if (!ic.inp_valid[i] && sent[i] < NT && $urandom_range(0, 3) != 0) begin
          ic.inp_data[i] = {2'(i), 14'(sent[i])};
          ic.inp_valid[i] = 1;
          sent[i]++;
        end
      ic.ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      hk = -1;
      if (ic.valid && ic.ready) begin
        hk = int'(ic.idx);
        total++;
        if (hk > 2) begin
          bad++; $display("FAIL rand_idx idx=%0d exp <3", hk);
          hk = -1;
        end else begin
          e = {2'(hk), 14'(got[hk])};
          if (ic.data !== e || ic.inp_ready !== 3'(1 << hk)) begin
            bad++; $display("FAIL rand_xfer data=%h rdy=%b exp %h", ic.data, ic.inp_ready, e);
          end
          got[hk]++;
        end
      end
      @(posedge clk); #1;
      if (hk >= 0) ic.inp_valid[hk] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] != NT) begin
        bad++; $display("FAIL rand_count[%0d] got=%0d exp %0d", i, got[i], NT);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rr();
    test_burst();
    test_flush_cnt();
    test_lock();
    test_flush_lock();
    test_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
